// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding logic.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writers downstream of execute.
// Entry 0 is youngest; the oldest entry drives the register-file retire port.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bubble,
  input  logic                           in_valid,
  input  logic [REG_AW-1:0]              in_rd,
  input  logic                           in_is_load,
  output logic [DEPTH-1:0]               sb_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   sb_rd,
  output logic [DEPTH-1:0]               sb_is_load,
  output logic                           retire_valid,
  output logic [REG_AW-1:0]              retire_rd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid   <= '0;
      sb_rd      <= '0;
      sb_is_load <= '0;
    end else begin
      sb_valid[0]   <= in_valid & ~bubble;
      sb_rd[0]      <= in_rd;
      sb_is_load[0] <= in_is_load;
      for (int i = 1; i < DEPTH; i++) begin
        sb_valid[i]   <= sb_valid[i-1];
        sb_rd[i]      <= sb_rd[i-1];
        sb_is_load[i] <= sb_is_load[i-1];
      end
    end
  end

  assign retire_valid = sb_valid[DEPTH-1];
  assign retire_rd    = sb_rd[DEPTH-1];

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, operand forwarding and branch flush for the RV32 pipeline.
// Define HAZARD_PERF_EN to implement the stall/flush performance counters.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter  int REG_AW   = pipe_pkg::REG_AW,
  parameter  int DEPTH    = 2,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall_f,
  output logic              flush_fd,
  output logic              issue,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              retire_valid,
  output logic [REG_AW-1:0] retire_rd,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic [DEPTH-1:0]             sb_valid;
  logic [DEPTH-1:0][REG_AW-1:0] sb_rd;
  logic [DEPTH-1:0]             sb_is_load;
  logic                         busy_a;
  logic                         busy_b;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (~issue),
    .in_valid     (id_valid & id_rd_we & (id_rd != '0)),
    .in_rd        (id_rd),
    .in_is_load   (id_is_load),
    .sb_valid     (sb_valid),
    .sb_rd        (sb_rd),
    .sb_is_load   (sb_is_load),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd)
  );

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_a_sel = SEL_W'(FWD_RF);
    fwd_b_sel = SEL_W'(FWD_RF);
    busy_a    = 1'b0;
    busy_b    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (id_rs1_used && (id_rs1 != '0) && sb_valid[i] && (sb_rd[i] == id_rs1)) begin
        fwd_a_sel = SEL_W'(i + 1);
        busy_a    = sb_is_load[i] && (i < LOAD_LAT);
      end
      if (id_rs2_used && (id_rs2 != '0) && sb_valid[i] && (sb_rd[i] == id_rs2)) begin
        fwd_b_sel = SEL_W'(i + 1);
        busy_b    = sb_is_load[i] && (i < LOAD_LAT);
      end
    end
  end

  assign stall_f  = id_valid & (busy_a | busy_b);
  assign issue    = id_valid & ~stall_f;
  assign flush_fd = br_taken & issue;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_fd && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard-checked bench for hazard_fwd_unit (DEPTH=2, LOAD_LAT=1).
module tb_hazard_fwd_unit;

  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic        id_rd_we = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;
  logic        stall_f, flush_fd, issue, retire_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [4:0]  retire_rd;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .br_taken(br_taken), .stall_f(stall_f), .flush_fd(flush_fd), .issue(issue),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // History of issued instructions, index = age in cycles since issue (0 = youngest).
  typedef struct {bit v; bit [4:0] rd; bit ld;} hist_t;
  typedef struct {
    bit stall; bit flush; bit issue; int fa; int fb;
    bit rv; bit [4:0] rr; longint sc; longint fc;
  } exp_t;

  hist_t  hist[$];
  exp_t   exp_q[$];
  int     checks = 0;
  int     passed = 0;
  longint m_sc = 0, m_fc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void find(input int src, input bit used, output int sel, output bit not_ready);
    sel = 0;
    not_ready = 1'b0;
    if (!used || src == 0) return;
    for (int a = 0; a < hist.size(); a++) begin
      if (hist[a].v && hist[a].rd == src[4:0]) begin
        sel = a + 1;
        not_ready = hist[a].ld && (a < LOAD_LAT);
        return;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit v, input int rs1, input int rs2,
                     input bit u1, input bit u2, input int rd, input bit we,
                     input bit ld, input bit br);
    exp_t e;
    int   sa, sb;
    bit   na, nb;
    @(negedge clk);
    rst = r; id_valid = v; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0];
    id_rs1_used = u1; id_rs2_used = u2; id_rd = rd[4:0];
    id_rd_we = we; id_is_load = ld; br_taken = br;
    #1;
    if (r) begin
      hist.delete();
      m_sc = 0;
      m_fc = 0;
    end
    find(rs1, u1, sa, na);
    find(rs2, u2, sb, nb);
    e.stall = v && (na || nb);
    e.issue = v && !e.stall;
    e.flush = br && e.issue;
    e.fa = sa;
    e.fb = sb;
    e.rv = (hist.size() >= DEPTH) && hist[DEPTH-1].v;
    e.rr = e.rv ? hist[DEPTH-1].rd : 5'd0;
    e.sc = PERF ? m_sc : 0;
    e.fc = PERF ? m_fc : 0;
    exp_q.push_back(e);
    if (!r) begin
      if (e.stall && m_sc < CNT_MAX) m_sc++;
      if (e.flush && m_fc < CNT_MAX) m_fc++;
      hist.push_front('{v: (v && we && rd != 0 && e.issue), rd: rd[4:0], ld: ld});
      while (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_f",      stall_f,      e.stall);
        chk("issue",        issue,        e.issue);
        chk("flush_fd",     flush_fd,     e.flush);
        chk("fwd_a_sel",    fwd_a_sel,    e.fa);
        chk("fwd_b_sel",    fwd_b_sel,    e.fb);
        chk("retire_valid", retire_valid, e.rv);
        if (e.rv) chk("retire_rd", retire_rd, e.rr);
        chk("stall_cnt",    stall_cnt,    e.sc);
        chk("flush_cnt",    flush_cnt,    e.fc);
      end
    end
  end

  initial begin : stim
    int t;
    //  r  v  rs1 rs2 u1 u2 rd we ld br
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 4, 1, 1, 2, 1, 0, 1);
    // RAW forward: producer, immediate consumer, then after one bubble
    cyc(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    // load-use on rs2, consumer held through the stall
    cyc(0, 1, 0, 0, 0, 0, 6, 1, 1, 0);
    cyc(0, 1, 0, 6, 0, 1, 8, 1, 0, 0);
    cyc(0, 1, 0, 6, 0, 1, 8, 1, 0, 0);
    // x0 producer and unused source
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
    cyc(0, 1, 0, 9, 0, 0, 0, 0, 0, 0);
    // youngest producer wins
    cyc(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(0, 1, 7, 0, 1, 0, 0, 0, 0, 0);
    // branch: clean flush, suppressed flush while stalled, then flush after stall
    cyc(0, 1, 1, 2, 1, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 6, 1, 1, 0);
    cyc(0, 1, 0, 6, 0, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 6, 0, 1, 1, 1, 0, 1);
    // taken jump with a link register still issues
    cyc(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    // reset mid-stall
    cyc(0, 1, 0, 0, 0, 0, 6, 1, 1, 0);
    cyc(0, 1, 6, 0, 1, 0, 2, 1, 0, 0);
    cyc(1, 1, 6, 0, 1, 0, 2, 1, 0, 1);
    cyc(0, 1, 6, 0, 1, 0, 2, 1, 0, 0);
    // randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 800; n++) begin
      cyc(($urandom % 120) == 0,
          ($urandom % 8) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom % 4) != 0, ($urandom % 4) != 0,
          $urandom_range(0, 3),
          ($urandom % 4) != 0,
          ($urandom % 3) == 0,
          ($urandom % 6) == 0);
    end
    t = 0;
    while (exp_q.size() > 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-detection and operand-forwarding controller for the pipelined RV32 core. It sits beside the decode/execute stage. It tracks every in-flight register-writing instruction downstream of execute in a shift-register scoreboard. From that scoreboard it drives the forwarding-mux selects for both ALU operands, load-use stalls with bubble insertion, and fetch/decode flushes on taken branches. It replaces the fixed, hard-wired forwarding selects with a unit that generalises to any downstream depth and load latency.

## Interface
- REG_AW, 5, register-address width
- DEPTH, 2, scoreboard entries = pipeline stages after execute that can forward (1..4)
- LOAD_LAT, 1, entry index at which load data becomes forwardable (0..DEPTH-1)
- SEL_W, $clog2(DEPTH+1), forward-select width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode/execute stage holds a valid instruction
- id_rs1, id_rs2  in  REG_AW  source register addresses
- id_rs1_used, id_rs2_used  in  1  instruction actually reads that source
- id_rd  in  REG_AW  destination register
- id_rd_we  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- br_taken  in  1  branch/jump resolved taken in execute
- stall_f  out  1  hold PC and the F/D register
- flush_fd  out  1  replace the F/D instruction with a NOP next cycle
- issue  out  1  execute instruction advances into the scoreboard this cycle
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = register file, k = scoreboard entry k-1
- retire_valid, retire_rd  out  1/REG_AW  entry DEPTH-1 is writing the register file this cycle
- stall_cnt, flush_cnt  out  32  performance counters

## Operation
- Each scoreboard entry holds valid, rd and is_load. Entry 0 is youngest.
- Every cycle the entries shift: entry i moves to entry i+1, and entry DEPTH-1 retires.
- Entry 0 loads {id_valid & id_rd_we & (id_rd!=0) & issue, id_rd, id_is_load}. A stall loads a bubble (valid=0).
- An entry matches a source when it is valid, its rd equals the source address, and the source's *_used bit is set.
- The x0 address never matches.
- Forward select = index+1 of the youngest matching entry, otherwise 0.
- A matching entry is not ready when it is_load and its index is < LOAD_LAT.
- stall_f = id_valid & (youngest match on rs1 or rs2 is not ready).
- issue = id_valid & !stall_f.
- flush_fd = br_taken & issue. br_taken is ignored while stalled, because the operands are stale.
- A taken jump with rd≠0 still issues into the scoreboard. Only F/D is flushed.
- stall_cnt increments on each stall_f cycle. flush_cnt increments on each flush_fd cycle. Both saturate at 2^32-1.
- During a stall, fwd selects still reflect the current matches. The execute result is discarded because issue=0.

## Timing
- All outputs except the counters are combinational from scoreboard state and the id_*/br_taken inputs. They have zero latency.
- Scoreboard and counters update on the rising edge of clk.
- Load-use stall lasts LOAD_LAT−idx cycles, then the consumer forwards from entry LOAD_LAT.
- With LOAD_LAT=0, stall_f is never asserted.
- Reset, including reset mid-stall: all entries invalid and counters 0. This immediately gives fwd selects 0, stall_f 0 and retire_valid 0.
- flush_fd and issue follow the inputs during reset.
- A producer in entry DEPTH-1 is both forwarded and retired in the same cycle. The register file is not required to be write-first.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt and flush_cnt are implemented as described.
- HAZARD_PERF_EN undefined: no counter flops; stall_cnt and flush_cnt are tied to 0. The ports remain present.

## Structure
- Shared package pipe_pkg:
  - typedef sb_entry_t {valid, rd, is_load}
  - constant FWD_RF = 0
  - REG_AW default
- Sub-module hazard_scoreboard: the DEPTH-entry shift register with bubble insert, async reset and the retire outputs. Match/priority logic and counters stay in hazard_fwd_unit.

## Test plan
All scenarios use DEPTH=2, LOAD_LAT=1.
- RAW forward: add x5 issued, next cycle add rs1=x5 → fwd_a_sel=1, stall_f=0; one bubble later → fwd_a_sel=2.
- Load-use: lw x6 issued, next instr uses rs2=x6 → stall_f=1 and issue=0 for exactly 1 cycle, then fwd_b_sel=2, stall_cnt=1.
- x0 / unused source: producer rd=x0, consumer rs1=x0 → fwd_a_sel=0. Producer x9 with id_rs2_used=0 on a matching rs2 → fwd_b_sel=0.
- Youngest-wins: two back-to-back producers of x7, consumer reads x7 → fwd_a_sel=1, not 2.
- Branch: br_taken with no hazard → flush_fd=1 and flush_cnt increments. br_taken while the load-use stall is active → flush_fd=0.
- Reset mid-stall: assert rst during the load-use stall → stall_f=0, fwd selects 0, retire_valid=0, counters 0 immediately. With HAZARD_PERF_EN undefined, counters read 0 throughout.
